// File: rtl/matvec_pkg.sv
// Shared types and defaults for the mat-vec load sequencer.
// Element width x row count must fill exactly one 64-bit memory word.
package matvec_pkg;

    localparam int MEM_WORD_W     = 64;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        REQ_A,
        WAIT_A,
        REQ_B,
        WAIT_B,
        STREAM_B,
        WAIT_MAC,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/avl_read_port.sv
// Single-outstanding Avalon read handshake with response timeout.
// Latency: request visible same cycle as req; rdata passes through combinationally.
// Backpressure: mem_read/mem_address held while mem_waitrequest; no new request while one is pending.
module avl_read_port
    import matvec_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = MEM_WORD_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              accepted,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              timeout,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_readdatavalid,
    input  logic              mem_waitrequest
);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic             pending;
    logic [TMR_W-1:0] timer;

    assign mem_read    = req && !pending;
    assign mem_address = mem_read ? addr : '0;
    assign accepted    = mem_read && !mem_waitrequest;
    // Strobes arriving with nothing outstanding are dropped here.
    assign rvalid      = pending && mem_readdatavalid;
    assign rdata       = mem_readdata;
    assign timeout     = pending && !mem_readdatavalid && (timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            timer   <= '0;
        end else if (accepted) begin
            pending <= 1'b1;
            timer   <= '0;
        end else if (pending) begin
            if (rvalid || timeout) begin
                pending <= 1'b0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matvec_load_ctrl.sv
// Sequencer: clear MAC, load DEPTH rows into A FIFOs, load vector word, stream it into B FIFO, await mac_done.
// Latency: A writes pass readdata through in the readdatavalid cycle; B streams DEPTH back-to-back cycles.
// Backpressure: memory stalls via waitrequest; one read outstanding; missing response -> ERR after TIMEOUT.
module matvec_load_ctrl
    import matvec_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  CLOCK_50,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           base_addr,
    output logic [31:0]           mem_address,
    output logic                  mem_read,
    input  logic [MEM_WORD_W-1:0] mem_readdata,
    input  logic                  mem_readdatavalid,
    input  logic                  mem_waitrequest,
    output logic                  mac_clr,
    output logic                  a_wren,
    output logic [MEM_WORD_W-1:0] a_data,
    output logic                  b_wren,
    output logic [DATA_WIDTH-1:0] b_data,
    input  logic                  mac_done,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int               CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       row_cnt;
    logic [CNT_W-1:0]       elem_cnt;
    logic [31:0]            base_reg;
    logic [MEM_WORD_W-1:0]  vec_reg;
    logic                   start_ok;
    logic                   rd_req;
    logic [31:0]            rd_addr;
    logic                   rd_accepted;
    logic [MEM_WORD_W-1:0]  rd_rdata;
    logic                   rd_rvalid;
    logic                   rd_timeout;

    assign start_ok = start && (state == IDLE || state == DONE || state == ERR);
    assign busy     = !(state == IDLE || state == DONE || state == ERR);
    assign done     = (state == DONE);
    assign error    = (state == ERR);

    avl_read_port #(
        .ADDR_W  (32),
        .DATA_W  (MEM_WORD_W),
        .TIMEOUT (TIMEOUT)
    ) u_rd (
        .CLOCK_50          (CLOCK_50),
        .rst_n             (rst_n),
        .req               (rd_req),
        .addr              (rd_addr),
        .accepted          (rd_accepted),
        .rdata             (rd_rdata),
        .rvalid            (rd_rvalid),
        .timeout           (rd_timeout),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_waitrequest   (mem_waitrequest)
    );

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            row_cnt  <= '0;
            elem_cnt <= '0;
            base_reg <= '0;
            vec_reg  <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                base_reg <= base_addr;
                row_cnt  <= '0;
            end
            if (state == WAIT_A && rd_rvalid && row_cnt != LAST) begin
                row_cnt <= row_cnt + 1'b1;
            end
            if (state == WAIT_B && rd_rvalid) begin
                vec_reg  <= rd_rdata;
                elem_cnt <= '0;
            end
            if (state == STREAM_B) begin
                elem_cnt <= elem_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mac_clr   = 1'b0;
        a_wren    = 1'b0;
        a_data    = '0;
        b_wren    = 1'b0;
        b_data    = '0;
        rd_req    = 1'b0;
        rd_addr   = base_reg;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                mac_clr   = 1'b1;
                state_nxt = REQ_A;
            end
            REQ_A: begin
                rd_req  = 1'b1;
                rd_addr = base_reg + 32'(row_cnt);
                if (rd_accepted) state_nxt = WAIT_A;
            end
            WAIT_A: begin
                if (rd_rvalid) begin
                    a_wren    = 1'b1;
                    a_data    = rd_rdata;
                    state_nxt = (row_cnt == LAST) ? REQ_B : REQ_A;
                end else if (rd_timeout) begin
                    state_nxt = ERR;
                end
            end
            REQ_B: begin
                rd_req  = 1'b1;
                rd_addr = base_reg + 32'(DEPTH);
                if (rd_accepted) state_nxt = WAIT_B;
            end
            WAIT_B: begin
                if (rd_rvalid) begin
                    state_nxt = STREAM_B;
                end else if (rd_timeout) begin
                    state_nxt = ERR;
                end
            end
            STREAM_B: begin
                b_wren = 1'b1;
                // Most significant element goes out first.
                for (int i = 0; i < DEPTH; i++) begin
                    if (elem_cnt == CNT_W'(i)) begin
                        b_data = vec_reg[(DEPTH-1-i)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                if (elem_cnt == LAST) state_nxt = WAIT_MAC;
            end
            WAIT_MAC: begin
                if (mac_done) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
